// File: rtl/prbs8_checker.sv
// Receive-side checker for the 8-bit Fibonacci PRBS (new = S7^S5^S4^S3).
// Seeds from the line, verifies predictions, then free-runs and counts bit errors.
module prbs8_checker #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i,
  input  logic                 valid,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned SEED_W = 4;
  localparam int unsigned GOOD_W = 8;
  localparam int unsigned MISS_W = 4;

  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]           state, state_nxt;
  logic [7:0]           hist, hist_nxt;
  logic [SEED_W-1:0]    seed_cnt, seed_nxt;
  logic [GOOD_W-1:0]    good_cnt, good_nxt;
  logic [MISS_W-1:0]    miss_cnt, miss_nxt;
  logic                 err_nxt;
  logic [ERR_CNT_W-1:0] err_count_nxt;
  logic                 pred_c;
  logic                 degen_c;
  logic                 match_c;

  // A history with S[7:3] all zero predicts zeros forever, so it never earns lock credit.
  assign pred_c  = hist[7] ^ hist[5] ^ hist[4] ^ hist[3];
  assign degen_c = (hist[7:3] == 5'd0);
  assign match_c = (i == pred_c);

  // Next-state, history, counters and error accounting.
  always_comb begin
    state_nxt     = state;
    hist_nxt      = hist;
    seed_nxt      = seed_cnt;
    good_nxt      = good_cnt;
    miss_nxt      = miss_cnt;
    err_nxt       = 1'b0;
    err_count_nxt = err_count;

    if (valid) begin
      case (state)
        ST_SEED: begin
          hist_nxt = {i, hist[7:1]};
          seed_nxt = seed_cnt + SEED_W'(1);
          if (seed_cnt == SEED_W'(7)) begin
            state_nxt = ST_VERIFY;
            good_nxt  = '0;
          end
        end
        ST_VERIFY: begin
          hist_nxt = {i, hist[7:1]};
          if (match_c && !degen_c) begin
            good_nxt = good_cnt + GOOD_W'(1);
            if ((good_cnt + GOOD_W'(1)) == GOOD_W'(LOCK_COUNT)) begin
              state_nxt = ST_LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            good_nxt = '0;
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so line errors never corrupt the reference.
          hist_nxt = {pred_c, hist[7:1]};
          if (!match_c) begin
            err_nxt  = 1'b1;
            miss_nxt = miss_cnt + MISS_W'(1);
            if (err_count != '1) begin
              err_count_nxt = err_count + ERR_CNT_W'(1);
            end
            if ((miss_cnt + MISS_W'(1)) == MISS_W'(LOSS_COUNT)) begin
              state_nxt = ST_SEED;
              seed_nxt  = '0;
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_SEED;
          seed_nxt  = '0;
        end
      endcase
    end

    if (clr_err) begin
      err_count_nxt = err_nxt ? ERR_CNT_W'(1) : '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SEED;
      hist      <= '0;
      seed_cnt  <= '0;
      good_cnt  <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      hist      <= hist_nxt;
      seed_cnt  <= seed_nxt;
      good_cnt  <= good_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= (state_nxt == ST_LOCKED);
      err       <= err_nxt;
      err_count <= err_count_nxt;
    end
  end

endmodule
